osd_stm_event_rx: RTL
=====================

# osd_stm_event_rx

Receiver for software trace (STM) event packets on the debug interconnect. Accepts DII flits addressed to this module, parses each STM event packet and presents it as one parallel record (source, timestamp, trace id, value) on a valid/ready output. Sits at the host-side or on-chip trace sink end of the STM path. Malformed and foreign packets are discarded and counted.

## Interface
- VALWIDTH, 32: trace value width in bits; multiple of 16, range 16–64.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id  in  16  own DII address; compared with the packet destination flit.
- debug_in  in  dii_flit  incoming flit (valid, last, data[15:0]).
- debug_in_ready  out  1  flit accepted when debug_in.valid && debug_in_ready.
- event_valid  out  1  decoded event available.
- event_ready  in  1  consumer accepts event when event_valid && event_ready.
- event_src  out  16  source address of the packet.
- event_timestamp  out  32  event timestamp.
- event_id  out  16  trace id.
- event_value  out  VALWIDTH  trace value.
- err_count  out  16  saturating count of discarded malformed packets.

## Operation
- Packet format, flit order, all fields little-endian by 16-bit word: F0 dest; F1 src; F2 header (type = [15:14], type_sub = [13:10]); F3–F4 timestamp [15:0], [31:16]; F5 id; F6… value words, VALWIDTH/16 flits, LSB word first. Last flit carries last=1. Packet length: 6 + VALWIDTH/16 flits (8 for VALWIDTH=32).
- Valid event packet: dest == id, type == 2'b10 (EVENT), type_sub == 0, length exact.
- FSM states: DEST, SRC, HDR, TS_LO, TS_HI, ID, VAL (word counter 0..VALWIDTH/16-1), DRAIN.
- DEST: on accepted flit, dest match -> SRC, else -> DRAIN (silent drop, not counted). If that flit has last=1, stay in DEST.
- SRC, HDR, TS_LO, TS_HI, ID, non-final VAL word: capture field into shadow registers and advance. Bad type/type_sub in HDR -> DRAIN, count error. Any last=1 in these states (premature end) -> DEST, count error, no event.
- Final VAL word: last=1 -> transfer shadow fields plus this word to output registers, set event_valid, -> DEST. last=0 (too long) -> DRAIN, count error, no event.
- DRAIN: accept and discard flits until one with last=1, then -> DEST.
- Output is a single-entry register, independent of shadow registers; parsing of the next packet proceeds while an event is pending.
- debug_in_ready = 1 in every state except: final VAL word while event_valid && !event_ready. In that case the flit stalls until the output slot frees.
- Same-cycle event_ready and final-word acceptance: old event retires and new event loads in one cycle; event_valid stays 1.
- err_count increments by 1 per discarded malformed packet; saturates at 16'hFFFF.

## Timing
- Reset (rst=0, async): state = DEST, event_valid = 0, event_src/timestamp/id/value = 0, err_count = 0, debug_in_ready = 1 from first cycle after release. Reset mid-packet abandons it without counting; next flit is treated as F0.
- Latency: event_valid rises the cycle after the final value flit is accepted. Output fields stable while event_valid && !event_ready.
- Throughput: one flit per cycle; back-to-back packets without bubbles when consumer accepts each event within the next packet's duration.
- err_count updates the cycle after the offending flit is accepted.
- No combinational path from debug_in to event outputs; debug_in_ready depends combinationally only on state, word counter, event_valid, event_ready.

## Test plan
- id=16'h0001, packet {0001, 0005, 8000, 5678, 1234, 0042, BEEF, DEAD(last)}, event_ready=1 -> one cycle later event_valid=1, src=0005, timestamp=32'h12345678, id=16'h0042, value=32'hDEADBEEF; err_count=0.
- Same packet with dest=16'h0002 -> all 8 flits accepted, no event, err_count=0.
- Packet with last=1 on F5 -> no event, err_count=1; following valid packet decodes correctly.
- Header F2=16'h4000 -> packet drained to last, no event, err_count=1; 9-flit packet (last on F8) -> no event, err_count=2.
- event_ready=0, two valid packets back to back -> first event held unchanged, debug_in_ready=0 on second packet's final flit; raise event_ready -> first retires, second loads same cycle, event_valid stays 1.
- Assert rst low mid-way through F3 of a packet -> outputs cleared asynchronously; after release, a complete valid packet decodes correctly, err_count=0.

Source files
------------

// File: rtl/osd_stm_event_rx.sv
// osd_stm_event_rx
//
// Receives STM event packets from the debug interconnect (DII) and turns each
// well-formed packet into a single parallel event record on a valid/ready
// output. Packets that are not addressed to this module are dropped silently.
// Malformed packets are dropped and counted in err_count.
//
// Packet layout, one 16-bit word per flit:
//   F0 dest, F1 src, F2 header (type [15:14], type_sub [13:10]),
//   F3/F4 timestamp low/high, F5 trace id, F6.. value words (LSB word first).
//   The final value flit carries last=1.
//
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   id                own DII address
//   debug_in_valid    incoming flit valid
//   debug_in_last     incoming flit is the last of its packet
//   debug_in_data     incoming flit payload
//   debug_in_ready    flit is accepted when valid && ready
//   event_valid       decoded event is available
//   event_ready       consumer accepts the event when valid && ready
//   event_src         source address of the event packet
//   event_timestamp   event timestamp
//   event_id          trace id
//   event_value       trace value
//   err_count         saturating count of discarded malformed packets
module osd_stm_event_rx #(
    parameter int VALWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         id,
    input  logic                debug_in_valid,
    input  logic                debug_in_last,
    input  logic [15:0]         debug_in_data,
    output logic                debug_in_ready,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [15:0]         event_src,
    output logic [31:0]         event_timestamp,
    output logic [15:0]         event_id,
    output logic [VALWIDTH-1:0] event_value,
    output logic [15:0]         err_count
);

    localparam int NWORDS = VALWIDTH / 16;
    // Two bits cover the full 1..4 value word range.
    localparam int CNTW = 2;
    localparam logic [CNTW-1:0] LAST_WORD = CNTW'(NWORDS - 1);

    typedef enum logic [2:0] {
        ST_DEST,
        ST_SRC,
        ST_HDR,
        ST_TS_LO,
        ST_TS_HI,
        ST_ID,
        ST_VAL,
        ST_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;

    // Shadow registers collecting the packet currently being parsed.
    logic [15:0]         src_q, src_d;
    logic [31:0]         ts_q, ts_d;
    logic [15:0]         tid_q, tid_d;
    logic [VALWIDTH-1:0] val_q, val_d;

    // Output slot, independent of the shadow registers.
    logic                ev_valid_q, ev_valid_d;
    logic [15:0]         ev_src_q, ev_src_d;
    logic [31:0]         ev_ts_q, ev_ts_d;
    logic [15:0]         ev_id_q, ev_id_d;
    logic [VALWIDTH-1:0] ev_val_q, ev_val_d;

    logic [15:0]         err_q, err_d;

    logic                accept;
    logic                final_word;
    logic                load_event;
    logic                err_inc;
    logic [VALWIDTH-1:0] val_full;

    // The final value flit may only be taken when the output slot is free or
    // is being emptied in this very cycle; everything else flows freely.
    assign final_word     = (state_q == ST_VAL) && (cnt_q == LAST_WORD);
    assign debug_in_ready = !(final_word && ev_valid_q && !event_ready);
    assign accept         = debug_in_valid && debug_in_ready;

    // Value as it will look once the flit currently presented is merged in.
    always_comb begin
        val_full = val_q;
        val_full[int'(cnt_q) * 16 +: 16] = debug_in_data;
    end

    // Packet parser: next-state, shadow capture, error and load decisions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        ts_d       = ts_q;
        tid_d      = tid_q;
        val_d      = val_q;
        err_inc    = 1'b0;
        load_event = 1'b0;

        if (accept) begin
            case (state_q)
                ST_DEST: begin
                    if (debug_in_last) begin
                        state_d = ST_DEST;
                    end else if (debug_in_data == id) begin
                        state_d = ST_SRC;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_SRC: begin
                    src_d = debug_in_data;
                    if (debug_in_last) begin
                        state_d = ST_DEST;
                        err_inc = 1'b1;
                    end else begin
                        state_d = ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (debug_in_last) begin
                        state_d = ST_DEST;
                        err_inc = 1'b1;
                    end else if (debug_in_data[15:14] != 2'b10 ||
                                 debug_in_data[13:10] != 4'd0) begin
                        state_d = ST_DRAIN;
                        err_inc = 1'b1;
                    end else begin
                        state_d = ST_TS_LO;
                    end
                end
                ST_TS_LO: begin
                    ts_d[15:0] = debug_in_data;
                    if (debug_in_last) begin
                        state_d = ST_DEST;
                        err_inc = 1'b1;
                    end else begin
                        state_d = ST_TS_HI;
                    end
                end
                ST_TS_HI: begin
                    ts_d[31:16] = debug_in_data;
                    if (debug_in_last) begin
                        state_d = ST_DEST;
                        err_inc = 1'b1;
                    end else begin
                        state_d = ST_ID;
                    end
                end
                ST_ID: begin
                    tid_d = debug_in_data;
                    cnt_d = '0;
                    if (debug_in_last) begin
                        state_d = ST_DEST;
                        err_inc = 1'b1;
                    end else begin
                        state_d = ST_VAL;
                    end
                end
                ST_VAL: begin
                    if (cnt_q == LAST_WORD) begin
                        if (debug_in_last) begin
                            load_event = 1'b1;
                            state_d    = ST_DEST;
                        end else begin
                            // Packet longer than an event: discard the rest.
                            state_d = ST_DRAIN;
                            err_inc = 1'b1;
                        end
                    end else begin
                        val_d = val_full;
                        if (debug_in_last) begin
                            state_d = ST_DEST;
                            err_inc = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (debug_in_last) begin
                        state_d = ST_DEST;
                    end
                end
                default: begin
                    state_d = ST_DEST;
                end
            endcase
        end
    end

    // Output slot: retire on handshake, then a new event may overwrite in the
    // same cycle so event_valid stays high across back-to-back events.
    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_src_d   = ev_src_q;
        ev_ts_d    = ev_ts_q;
        ev_id_d    = ev_id_q;
        ev_val_d   = ev_val_q;

        if (ev_valid_q && event_ready) begin
            ev_valid_d = 1'b0;
        end
        if (load_event) begin
            ev_valid_d = 1'b1;
            ev_src_d   = src_q;
            ev_ts_d    = ts_q;
            ev_id_d    = tid_q;
            ev_val_d   = val_full;
        end
    end

    // Error counter sticks at all-ones instead of wrapping.
    always_comb begin
        err_d = err_q;
        if (err_inc && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_DEST;
            cnt_q      <= '0;
            src_q      <= '0;
            ts_q       <= '0;
            tid_q      <= '0;
            val_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_src_q   <= '0;
            ev_ts_q    <= '0;
            ev_id_q    <= '0;
            ev_val_q   <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            ts_q       <= ts_d;
            tid_q      <= tid_d;
            val_q      <= val_d;
            ev_valid_q <= ev_valid_d;
            ev_src_q   <= ev_src_d;
            ev_ts_q    <= ev_ts_d;
            ev_id_q    <= ev_id_d;
            ev_val_q   <= ev_val_d;
            err_q      <= err_d;
        end
    end

    assign event_valid     = ev_valid_q;
    assign event_src       = ev_src_q;
    assign event_timestamp = ev_ts_q;
    assign event_id        = ev_id_q;
    assign event_value     = ev_val_q;
    assign err_count       = err_q;

endmodule
